// File: rtl/matrix_mult_stream_if.sv
// Handshake bundle for matrix_mult_stream.
//   master : operand source / result consumer side (drives start, data_in,
//            in_valid, out_ready)
//   slave  : the multiplier (drives in_ready, data_out, out_valid, busy, done)
// DW and OW must match the parameters of the attached multiplier.
interface matrix_mult_stream_if #(
  parameter int DW = 8,
  parameter int OW = 17
);
  logic          start;
  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] data_out;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport master (
    output start, data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, busy, done
  );

  modport slave (
    input  start, data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, busy, done
  );
endinterface

// File: rtl/matrix_mult_stream.sv
// Streaming matrix multiplier C = A x B (A is MxK, B is KxN, C is MxN).
// Operands arrive serially (A row-major, then B row-major) on a valid/ready
// handshake, one MAC per cycle computes C, and C is streamed out row-major
// with backpressure.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of matrix_mult_stream_if (start, data_in/in_valid/
//          in_ready, data_out/out_valid/out_ready, busy, done)
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD_A  | accepting M*K elements of A
// S_LOAD_B  | accepting K*N elements of B
// S_COMPUTE | one multiply-accumulate per cycle, M*N*K cycles
// S_OUTPUT  | presenting C[idx] until the consumer takes it
// S_DONE    | one-cycle done pulse
module matrix_mult_stream #(
  parameter int DW     = 8,
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int SIGNED = 0,
  parameter int OW     = 2*DW + $clog2(K)
) (
  input logic                clk,
  input logic                reset,
  matrix_mult_stream_if.slave bus
);

  // Product is widened to at least OW before being cut back to OW, so a
  // narrow OW simply wraps.
  localparam int PW = (OW > 2*DW) ? OW : 2*DW;
  localparam int CW = $clog2(M*K + K*N + M*N + 2);

  localparam logic [CW-1:0] LAST_A = CW'(M*K - 1);
  localparam logic [CW-1:0] LAST_B = CW'(K*N - 1);
  localparam logic [CW-1:0] LAST_C = CW'(M*N - 1);
  localparam logic [CW-1:0] LAST_M = CW'(M - 1);
  localparam logic [CW-1:0] LAST_N = CW'(N - 1);
  localparam logic [CW-1:0] LAST_K = CW'(K - 1);
  localparam logic [CW-1:0] K_C    = CW'(K);
  localparam logic [CW-1:0] N_C    = CW'(N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_OUTPUT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ld_q, ld_d, i_q, i_d, j_q, j_d, k_q, k_d, oidx_q, oidx_d;
  logic [OW-1:0] acc_q, acc_d;
  logic          c_we, wr_a, wr_b;

  logic [DW-1:0] a_q [M*K];
  logic [DW-1:0] b_q [K*N];
  logic [OW-1:0] c_q [M*N];

  logic [CW-1:0]          a_idx, b_idx, c_idx;
  logic [DW-1:0]          a_rd, b_rd;
  logic [OW-1:0]          c_rd, prod_ext;
  logic [2*DW-1:0]        prod_u;
  logic signed [2*DW-1:0] prod_s;
  logic [PW-1:0]          ext_u;
  logic signed [PW-1:0]   ext_s;

  assign a_idx = i_q * K_C + k_q;
  assign b_idx = k_q * N_C + j_q;
  assign c_idx = i_q * N_C + j_q;

  // Compare-based read muxes avoid index-width mismatches for any M/K/N.
  always_comb begin
    a_rd = '0;
    b_rd = '0;
    c_rd = '0;
    for (int n = 0; n < M*K; n++) if (a_idx == CW'(n)) a_rd = a_q[n];
    for (int n = 0; n < K*N; n++) if (b_idx == CW'(n)) b_rd = b_q[n];
    for (int n = 0; n < M*N; n++) if (oidx_q == CW'(n)) c_rd = c_q[n];
  end

  always_comb begin
    prod_u   = {{DW{1'b0}}, a_rd} * {{DW{1'b0}}, b_rd};
    prod_s   = $signed({{DW{a_rd[DW-1]}}, a_rd}) * $signed({{DW{b_rd[DW-1]}}, b_rd});
    ext_u    = PW'(prod_u);
    ext_s    = PW'(prod_s);
    prod_ext = (SIGNED != 0) ? ext_s[OW-1:0] : ext_u[OW-1:0];
  end

  assign wr_a = (state_q == S_LOAD_A) && bus.in_valid;
  assign wr_b = (state_q == S_LOAD_B) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    oidx_d  = oidx_q;
    acc_d   = acc_q;
    c_we    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_LOAD_A;
        ld_d    = '0;
      end
      S_LOAD_A: if (bus.in_valid) begin
        if (ld_q == LAST_A) begin
          ld_d    = '0;
          state_d = S_LOAD_B;
        end else ld_d = ld_q + 1'b1;
      end
      S_LOAD_B: if (bus.in_valid) begin
        if (ld_q == LAST_B) begin
          ld_d    = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = S_COMPUTE;
        end else ld_d = ld_q + 1'b1;
      end
      S_COMPUTE: begin
        acc_d = ((k_q == '0) ? '0 : acc_q) + prod_ext;
        if (k_q == LAST_K) begin
          c_we = 1'b1;
          k_d  = '0;
          if (j_q == LAST_N) begin
            j_d = '0;
            if (i_q == LAST_M) begin
              i_d     = '0;
              oidx_d  = '0;
              state_d = S_OUTPUT;
            end else i_d = i_q + 1'b1;
          end else j_d = j_q + 1'b1;
        end else k_d = k_q + 1'b1;
      end
      S_OUTPUT: if (bus.out_ready) begin
        if (oidx_q == LAST_C) begin
          oidx_d  = '0;
          state_d = S_DONE;
        end else oidx_d = oidx_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      oidx_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      oidx_q  <= oidx_d;
      acc_q   <= acc_d;
    end
  end

  // Matrix storage survives reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < M*K; n++) if (wr_a && ld_q == CW'(n)) a_q[n] <= bus.data_in;
    for (int n = 0; n < K*N; n++) if (wr_b && ld_q == CW'(n)) b_q[n] <= bus.data_in;
    for (int n = 0; n < M*N; n++) if (c_we && c_idx == CW'(n)) c_q[n] <= acc_d;
  end

  assign bus.in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.data_out  = (state_q == S_OUTPUT) ? c_rd : '0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_mult_stream.sv
module tb_matrix_mult_stream;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut0: 2x2x2 unsigned, dut1: M=2 K=3 N=1 unsigned, dut2: 1x1x1 signed
  matrix_mult_stream_if #(.DW(8), .OW(17)) bus0 ();
  matrix_mult_stream_if #(.DW(8), .OW(18)) bus1 ();
  matrix_mult_stream_if #(.DW(8), .OW(16)) bus2 ();

  matrix_mult_stream #(.DW(8), .M(2), .K(2), .N(2), .SIGNED(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  matrix_mult_stream #(.DW(8), .M(2), .K(3), .N(1), .SIGNED(0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  matrix_mult_stream #(.DW(8), .M(1), .K(1), .N(1), .SIGNED(1)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic       start_r = 1'b0;
  logic [7:0] din_r = 8'h00;
  logic       inv_r = 1'b0;
  logic       ordy_r = 1'b0;
  int         sel = 0;

  // Only the selected DUT sees start; the others stay idle.
  assign bus0.start = start_r && (sel == 0);
  assign bus1.start = start_r && (sel == 1);
  assign bus2.start = start_r && (sel == 2);
  assign bus0.data_in = din_r;  assign bus1.data_in = din_r;  assign bus2.data_in = din_r;
  assign bus0.in_valid = inv_r; assign bus1.in_valid = inv_r; assign bus2.in_valid = inv_r;
  assign bus0.out_ready = ordy_r; assign bus1.out_ready = ordy_r; assign bus2.out_ready = ordy_r;

  logic   c_in_ready, c_out_valid, c_busy, c_done;
  longint c_dout;
  always_comb begin
    c_in_ready = bus0.in_ready; c_out_valid = bus0.out_valid;
    c_busy = bus0.busy; c_done = bus0.done; c_dout = longint'(bus0.data_out);
    if (sel == 1) begin
      c_in_ready = bus1.in_ready; c_out_valid = bus1.out_valid;
      c_busy = bus1.busy; c_done = bus1.done; c_dout = longint'(bus1.data_out);
    end else if (sel == 2) begin
      c_in_ready = bus2.in_ready; c_out_valid = bus2.out_valid;
      c_busy = bus2.busy; c_done = bus2.done; c_dout = longint'(bus2.data_out);
    end
  end

  int cyc = 0;
  int done_cnt [3] = '{0, 0, 0};
  always @(posedge clk) begin
    cyc++;
    if (bus0.done) done_cnt[0]++;
    if (bus1.done) done_cnt[1]++;
    if (bus2.done) done_cnt[2]++;
  end

  int checks = 0;
  int errors = 0;

  int m_, k_, n_, ow_;
  bit sgn_;
  int opa [$];
  int opb [$];
  longint exp_q [$];
  longint got_q [$];
  int lat, comp_cycles;
  bit stable_bad, timeout, done_after, ov_after, idle_after;

  task automatic set_sel(input int s);
    sel = s;
    case (s)
      0: begin m_ = 2; k_ = 2; n_ = 2; sgn_ = 0; ow_ = 17; end
      1: begin m_ = 2; k_ = 3; n_ = 1; sgn_ = 0; ow_ = 18; end
      default: begin m_ = 1; k_ = 1; n_ = 1; sgn_ = 1; ow_ = 16; end
    endcase
  endtask

  // Plain matrix product, reduced modulo 2^ow_.
  function automatic void model();
    longint sum, a, b;
    exp_q.delete();
    for (int i = 0; i < m_; i++)
      for (int j = 0; j < n_; j++) begin
        sum = 0;
        for (int kk = 0; kk < k_; kk++) begin
          a = opa[i*k_ + kk];
          b = opb[kk*n_ + j];
          if (sgn_) begin
            if (a >= 128) a -= 256;
            if (b >= 128) b -= 256;
          end
          sum += a * b;
        end
        exp_q.push_back(sum & ((longint'(1) << ow_) - 1));
      end
  endfunction

  // Runs one operation on the selected DUT. Feeds nfeed operands; if that is
  // fewer than all of them it returns right after the last transfer.
  task automatic run_op(input bit stall_in, input bit stall_out, input bit mid_start, input int nfeed);
    int ops [$];
    int idx, t0, hold, guard;
    bit xfer, prev_stalled;
    longint prev_d;
    ops = {opa, opb};
    idx = 0; guard = 0; hold = 0;
    got_q.delete();
    stable_bad = 0; timeout = 0; lat = -1; comp_cycles = 0;
    done_after = 0; ov_after = 1; idle_after = 0;
    @(negedge clk);
    start_r = 1'b1;
    t0 = cyc;
    while (idx < nfeed && guard < 500) begin
      @(negedge clk);
      guard++;
      start_r = mid_start && (idx == 3);
      inv_r = stall_in ? guard[0] : 1'b1;
      din_r = 8'(ops[idx]);
      xfer = inv_r && c_in_ready;
      @(posedge clk);
      if (xfer) idx++;
    end
    if (idx < nfeed) begin timeout = 1; inv_r = 0; start_r = 0; return; end
    if (nfeed < ops.size()) return;
    timeout = 1;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      inv_r = 1'b0;
      start_r = 1'b0;
      if (c_out_valid) begin timeout = 0; break; end
      comp_cycles++;
    end
    if (timeout) return;
    lat = cyc - t0;
    prev_stalled = 0; prev_d = 0;
    timeout = 1;
    for (int g = 0; g < 500; g++) begin
      ordy_r = !(stall_out && hold < 3);
      if (stall_out && hold < 3) hold++;
      if (prev_stalled && (c_dout !== prev_d || !c_out_valid)) stable_bad = 1;
      if (c_out_valid && ordy_r) got_q.push_back(c_dout);
      prev_stalled = c_out_valid && !ordy_r;
      prev_d = c_dout;
      if (got_q.size() == m_*n_) begin timeout = 0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    ordy_r = 1'b0;
    done_after = c_done;
    ov_after = c_out_valid;
    @(negedge clk);
    idle_after = !c_busy && !c_done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.in_ready, bus0.out_valid, bus0.busy, bus0.done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus0.in_ready, bus0.out_valid, bus0.busy, bus0.done});
    end
    checks++;
    if (bus0.data_out !== 17'd0) begin errors++; $display("FAIL reset_data_out: got %0d expected 0", bus0.data_out); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_case1();
    int exp1 [4] = '{19, 22, 43, 50};
    int d0;
    set_sel(0); opa = {1, 2, 3, 4}; opb = {5, 6, 7, 8};
    d0 = done_cnt[0];
    run_op(0, 0, 0, 8);
    checks++;
    if (got_q.size() != 4 || timeout) begin errors++; $display("FAIL case1_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i] !== longint'(exp1[i])) begin errors++; $display("FAIL case1_c%0d: got %0d expected %0d", i, got_q[i], exp1[i]); end
    end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL case1_latency: got %0d expected 17", lat); end
    checks++;
    if (!done_after || ov_after) begin errors++; $display("FAIL case1_done_cycle: got done=%0d out_valid=%0d expected 1 0", done_after, ov_after); end
    checks++;
    if (!idle_after) begin errors++; $display("FAIL case1_idle: got %0d expected 1", idle_after); end
    checks++;
    if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL case1_done_pulses: got %0d expected 1", done_cnt[0] - d0); end
  endtask

  task automatic test_shape();
    set_sel(1); opa = {1, 2, 3, 4, 5, 6}; opb = {1, 1, 1};
    run_op(0, 0, 0, 9);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 64'd6 || got_q[1] !== 64'd15) begin
      errors++; $display("FAIL shape_results: got %0d,%0d expected 6,15", got_q[0], got_q[1]);
    end
    checks++;
    if (comp_cycles != 6) begin errors++; $display("FAIL shape_compute_cycles: got %0d expected 6", comp_cycles); end
    checks++;
    if (lat != 16) begin errors++; $display("FAIL shape_latency: got %0d expected 16", lat); end
  endtask

  task automatic test_max();
    set_sel(0); opa = {255, 255, 255, 255}; opb = {255, 255, 255, 255};
    run_op(0, 0, 0, 8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i] !== 64'd130050) begin errors++; $display("FAIL max_c%0d: got %0d expected 130050", i, got_q[i]); end
    end
  endtask

  task automatic test_signed();
    set_sel(2); opa = {8'hFD}; opb = {8'h05};
    run_op(0, 0, 0, 2);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 64'hFFF1) begin errors++; $display("FAIL signed_result: got %0h expected fff1", got_q[0]); end
  endtask

  task automatic test_stall();
    int d0;
    set_sel(0); opa = {1, 2, 3, 4}; opb = {5, 6, 7, 8};
    model();
    d0 = done_cnt[0];
    run_op(1, 1, 1, 8);
    checks++;
    if (got_q.size() != 4 || timeout) begin errors++; $display("FAIL stall_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_c%0d: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (stable_bad) begin errors++; $display("FAIL stall_hold: got unstable output expected stable"); end
    checks++;
    if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL stall_done_pulses: got %0d expected 1", done_cnt[0] - d0); end
  endtask

  task automatic test_abort();
    int d0;
    set_sel(0); opa = {9, 9, 9, 9}; opb = {9, 9, 9, 9};
    d0 = done_cnt[0];
    run_op(0, 0, 0, 6);
    @(negedge clk);
    inv_r = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus0.in_ready, bus0.out_valid, bus0.busy, bus0.done} !== 4'b0000) begin
      errors++; $display("FAIL abort_ctrl: got %b expected 0000", {bus0.in_ready, bus0.out_valid, bus0.busy, bus0.done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt[0] != d0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt[0] - d0); end
    opa = {1, 2, 3, 4}; opb = {5, 6, 7, 8};
    model();
    run_op(0, 0, 0, 8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_rerun_c%0d: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 9; t++) begin
      set_sel(t % 3);
      opa.delete(); opb.delete();
      for (int i = 0; i < m_*k_; i++) opa.push_back(int'($urandom_range(0, 255)));
      for (int i = 0; i < k_*n_; i++) opb.push_back(int'($urandom_range(0, 255)));
      model();
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, m_*k_ + k_*n_);
      checks++;
      if (got_q.size() != exp_q.size() || timeout) begin
        errors++; $display("FAIL rand%0d_count: got %0d expected %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_c%0d: got %0d expected %0d", t, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_case1();
    test_shape();
    test_max();
    test_signed();
    test_stall();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
